// File: rtl/ntt_stage_sched_if.sv
// Bundle between the NTT stage scheduler and its controller/datapath.
// The scheduler connects to the slave modport. The controller or bench
// connects to the master modport.
//
// Signalling:
//   start is a request that is taken only while the scheduler is idle.
//   rd_en qualifies rd_row/rd_bank in the same cycle.
//   wr_en qualifies wr_row/wr_bank/wr_r4 in the same cycle.
//   There is no back-pressure.
//   All qualified fields read as 0 when their enable is low.
interface ntt_stage_sched_if #(
   parameter int AW = 5
);
   logic            start;
   logic            mode;
   logic            busy;
   logic            done;
   logic [3:0]      stage;
   logic            r4;
   logic [AW-1:0]   cnt;
   logic            rd_en;
   logic [4*AW-1:0] rd_row;
   logic [7:0]      rd_bank;
   logic            wr_en;
   logic [4*AW-1:0] wr_row;
   logic [7:0]      wr_bank;
   logic            wr_r4;
   logic            conflict_err;
   logic [1:0]      dbg_state;

   modport master (
      output start, mode,
      input  busy, done, stage, r4, cnt, rd_en, rd_row, rd_bank,
             wr_en, wr_row, wr_bank, wr_r4, conflict_err, dbg_state
   );

   modport slave (
      input  start, mode,
      output busy, done, stage, r4, cnt, rd_en, rd_row, rd_bank,
             wr_en, wr_row, wr_bank, wr_r4, conflict_err, dbg_state
   );
endinterface

// File: rtl/ntt_stage_sched.sv
// Stage scheduler for the 4-bank mixed-radix NTT datapath.
//
// The scheduler sequences radix-2 or radix-4 stages over N = 2^LOG_N points.
// Each issue cycle it emits four bank-conflict-free read addresses.
// It then replays those addresses as write-backs after the butterfly
// latency of the stage type.
//
// Optional feature: define NTT_SCHED_CONFLICT_CHK_EN to build a sticky
// bank-conflict checker. Without it, conflict_err is tied to 0.
module ntt_stage_sched #(
   parameter int LOG_N   = 7,
   parameter int BF_LAT  = 7,
   parameter int BF_LAT4 = 13
) (
   input  logic             clk,
   input  logic             rst,
   ntt_stage_sched_if.slave sched
);

   localparam int AW    = LOG_N - 2;
   localparam int NS_R2 = LOG_N;
   localparam int NR4   = LOG_N / 2;
   localparam int NS_R4 = NR4 + (LOG_N % 2);
   localparam int DW    = $clog2(BF_LAT4 + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic logic [LOG_N-1:0] even_mask();
      logic [LOG_N-1:0] v;
      v = '0;
      for (int j = 0; j < LOG_N; j += 2) v[j] = 1'b1;
      return v;
   endfunction

   localparam logic [LOG_N-1:0] EVEN_MASK = even_mask();

   // Opens a zero bit at position p and shifts the higher bits up by one.
   function automatic logic [LOG_N-1:0] ins_zero(input logic [LOG_N-1:0] v,
                                                 input logic [3:0]       p);
      logic [LOG_N-1:0] lo_mask;
      lo_mask = (LOG_N'(1) << p) - LOG_N'(1);
      return ((v >> p) << (p + 4'd1)) | (v & lo_mask);
   endfunction

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_stage, w_stage_nxt;
   logic [AW-1:0]   r_cnt,   w_cnt_nxt;
   logic [DW-1:0]   r_dcnt,  w_dcnt_nxt;
   logic            r_mode,  w_mode_nxt;
   logic            r_done,  w_done_nxt;

   logic            w_busy, w_rd_en, w_r4, w_last_stage;
   logic [3:0]      w_s, w_q, w_p0, w_p1, w_lo, w_hi;
   logic [LOG_N-1:0] w_a, w_idx;
   logic [4*AW-1:0] w_rd_row;
   logic [7:0]      w_rd_bank;

   // Write-back shift line: one entry per cycle, carrying r4 so the tap
   // can be chosen per entry.
   logic            r_pv    [BF_LAT4];
   logic [4*AW-1:0] r_prow  [BF_LAT4];
   logic [7:0]      r_pbank [BF_LAT4];
   logic            r_pr4   [BF_LAT4];
   logic            w_tap2, w_tap4;

   assign w_busy       = (r_state != IDLE);
   assign w_rd_en      = (r_state == ISSUE);
   assign w_r4         = w_busy && r_mode && (r_stage < 4'(NR4));
   assign w_last_stage = (r_stage == (r_mode ? 4'(NS_R4 - 1) : 4'(NS_R2 - 1)));

   // FSM state register plus the per-stage counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_stage <= '0;
         r_cnt   <= '0;
         r_dcnt  <= '0;
         r_mode  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_mode  <= w_mode_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic: issue N/4 cycles, then drain the butterfly
   // latency, then either start the next stage or finish the transform.
   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_cnt_nxt   = r_cnt;
      w_dcnt_nxt  = r_dcnt;
      w_mode_nxt  = r_mode;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (sched.start) begin
               w_state_nxt = ISSUE;
               w_stage_nxt = '0;
               w_cnt_nxt   = '0;
               w_mode_nxt  = sched.mode;
            end
         end
         ISSUE: begin
            w_cnt_nxt = r_cnt + AW'(1);
            if (r_cnt == {AW{1'b1}}) begin
               w_state_nxt = DRAIN;
               w_cnt_nxt   = '0;
               w_dcnt_nxt  = w_r4 ? DW'(BF_LAT4) : DW'(BF_LAT);
            end
         end
         DRAIN: begin
            w_dcnt_nxt = r_dcnt - DW'(1);
            if (r_dcnt == DW'(1)) begin
               w_cnt_nxt = '0;
               if (w_last_stage) begin
                  w_state_nxt = IDLE;
                  w_stage_nxt = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ISSUE;
                  w_stage_nxt = r_stage + 4'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Butterfly bit positions for the current stage.
   // The radix-2 tail of mode 1 always uses stride bit LOG_N-1.
   always_comb begin
      w_s = r_mode ? 4'(LOG_N - 1) : r_stage;
      if ((w_s ^ 4'd1) < 4'(LOG_N)) w_q = w_s ^ 4'd1;
      else                          w_q = w_s[0] ? 4'd0 : 4'd1;
      if (w_r4) begin
         w_p0 = {r_stage[2:0], 1'b0};
         w_p1 = {r_stage[2:0], 1'b1};
      end else begin
         w_p0 = w_s;
         w_p1 = w_q;
      end
      w_lo = (w_p0 < w_p1) ? w_p0 : w_p1;
      w_hi = (w_p0 < w_p1) ? w_p1 : w_p0;
      w_a  = ins_zero(ins_zero(LOG_N'(r_cnt), w_lo), w_hi);
   end

   // Lane addresses.
   // The bank is the parity of the odd bits and the parity of the even bits.
   // The two butterfly bits differ in parity class, so the four lanes
   // always land in four distinct banks.
   always_comb begin
      w_rd_row  = '0;
      w_rd_bank = '0;
      w_idx     = '0;
      for (int m = 0; m < 4; m++) begin
         w_idx = w_a | (LOG_N'(m % 2) << w_p0) | (LOG_N'(m / 2) << w_p1);
         if (w_rd_en) begin
            w_rd_row[m*AW +: AW] = w_idx[LOG_N-1:2];
            w_rd_bank[2*m +: 2]  = {^(w_idx & ~EVEN_MASK), ^(w_idx & EVEN_MASK)};
         end
      end
   end

   // Write-back delay line. It is cleared on reset so that an aborted
   // transform leaves no stray writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BF_LAT4; i++) begin
            r_pv[i]    <= 1'b0;
            r_prow[i]  <= '0;
            r_pbank[i] <= '0;
            r_pr4[i]   <= 1'b0;
         end
      end else begin
         r_pv[0]    <= w_rd_en;
         r_prow[0]  <= w_rd_row;
         r_pbank[0] <= w_rd_bank;
         r_pr4[0]   <= w_r4;
         for (int i = 1; i < BF_LAT4; i++) begin
            r_pv[i]    <= r_pv[i-1];
            r_prow[i]  <= r_prow[i-1];
            r_pbank[i] <= r_pbank[i-1];
            r_pr4[i]   <= r_pr4[i-1];
         end
      end
   end

   assign w_tap2 = r_pv[BF_LAT-1]  && !r_pr4[BF_LAT-1];
   assign w_tap4 = r_pv[BF_LAT4-1] &&  r_pr4[BF_LAT4-1];

   assign sched.busy      = w_busy;
   assign sched.done      = r_done;
   assign sched.stage     = r_stage;
   assign sched.r4        = w_r4;
   assign sched.cnt       = r_cnt;
   assign sched.rd_en     = w_rd_en;
   assign sched.rd_row    = w_rd_row;
   assign sched.rd_bank   = w_rd_bank;
   assign sched.wr_en     = w_tap2 | w_tap4;
   assign sched.wr_row    = w_tap4 ? r_prow[BF_LAT4-1]  : (w_tap2 ? r_prow[BF_LAT-1]  : '0);
   assign sched.wr_bank   = w_tap4 ? r_pbank[BF_LAT4-1] : (w_tap2 ? r_pbank[BF_LAT-1] : '0);
   assign sched.wr_r4     = w_tap4;
   assign sched.dbg_state = r_state;

`ifdef NTT_SCHED_CONFLICT_CHK_EN
   logic r_conflict;
   logic w_pair_eq;

   assign w_pair_eq = (w_rd_bank[1:0] == w_rd_bank[3:2]) ||
                      (w_rd_bank[1:0] == w_rd_bank[5:4]) ||
                      (w_rd_bank[1:0] == w_rd_bank[7:6]) ||
                      (w_rd_bank[3:2] == w_rd_bank[5:4]) ||
                      (w_rd_bank[3:2] == w_rd_bank[7:6]) ||
                      (w_rd_bank[5:4] == w_rd_bank[7:6]);

   // Sticky conflict flag. Only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_conflict <= 1'b0;
      else     r_conflict <= r_conflict | (w_rd_en & w_pair_eq);
   end

   assign sched.conflict_err = r_conflict;
`else
   assign sched.conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched with the default parameters.
// LOG_N=7 (N/4 = 32), BF_LAT=7, BF_LAT4=13.
module tb_ntt_stage_sched;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ntt_stage_sched_if #(.AW(5)) bus ();

   ntt_stage_sched #(.LOG_N(7), .BF_LAT(7), .BF_LAT4(13)) dut (
      .clk   (clk),
      .rst   (rst),
      .sched (bus)
   );

   logic [73:0] w_outs;
   logic [14:0] w_ctrl;
   logic [27:0] w_rd_data, w_wr_data;

   assign w_outs    = {bus.busy, bus.done, bus.stage, bus.r4, bus.cnt, bus.rd_en,
                       bus.rd_row, bus.rd_bank, bus.wr_en, bus.wr_row, bus.wr_bank,
                       bus.wr_r4, bus.conflict_err, bus.dbg_state};
   assign w_ctrl    = {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.r4, bus.wr_r4,
                       bus.stage, bus.cnt};
   assign w_rd_data = {bus.rd_row, bus.rd_bank};
   assign w_wr_data = {bus.wr_row, bus.wr_bank};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Schedule model: cycle t counts from the first ISSUE cycle.
   function automatic logic [14:0] exp_ctrl(input logic m, input int t);
      int          ns, base, lat;
      logic        busy, done, rd, wr, r4, wr4;
      logic [3:0]  st;
      logic [4:0]  c;
      busy = 0; done = 0; rd = 0; wr = 0; r4 = 0; wr4 = 0; st = 0; c = 0;
      ns   = m ? 4 : 7;
      base = 0;
      for (int s = 0; s < ns; s++) begin
         lat = (m && s < 3) ? 13 : 7;
         if (t >= base && t < base + 32 + lat) begin
            busy = 1;
            st   = 4'(s);
            r4   = m && s < 3;
            if (t < base + 32) begin
               rd = 1;
               c  = 5'(t - base);
            end
         end
         if (t >= base + lat && t < base + lat + 32) begin
            wr  = 1;
            wr4 = m && s < 3;
         end
         base += 32 + lat;
      end
      if (t == base) done = 1;
      return {busy, done, rd, wr, r4, wr4, st, c};
   endfunction

   task automatic run(input logic m, input int total, input int exp_rw, input int abort_t);
      int n_busy, n_rd, n_wr, n_done;
      n_busy = 0; n_rd = 0; n_wr = 0; n_done = 0;
      @(negedge clk);
      bus.mode  = m;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t <= total + 2; t++) begin
         if (t == abort_t) begin
            rst = 1'b1;
            #1;
            check("reset_mid_run_outs", 128'(w_outs), 128'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               check("post_reset_quiet", 128'({bus.busy, bus.rd_en, bus.wr_en, bus.done}), 128'd0);
            end
            return;
         end
         check($sformatf("ctrl_m%0d_t%0d", m, t), 128'(w_ctrl), 128'(exp_ctrl(m, t)));
         n_busy += int'(bus.busy);
         n_rd   += int'(bus.rd_en);
         n_wr   += int'(bus.wr_en);
         n_done += int'(bus.done);
         if (!m) begin
            if (t == 0)   check("m0_s0_c0_rd",   128'(w_rd_data), 128'({20'd0, 8'b11100100}));
            if (t == 32)  check("m0_drain_rd0",  128'(w_rd_data), 128'd0);
            if (t == 79)  check("m0_s2_c1_rd",   128'(w_rd_data), 128'({5'd3, 5'd2, 5'd1, 5'd0, 8'b10110001}));
            if (t == 86)  check("m0_s2_c1_wr",   128'(w_wr_data), 128'({5'd3, 5'd2, 5'd1, 5'd0, 8'b10110001}));
            if (t == 265) check("m0_s6_c31_rd",  128'(w_rd_data), 128'({5'd31, 5'd15, 5'd31, 5'd15, 8'b10110001}));
            if (t == 272) check("m0_s6_c31_wr",  128'(w_wr_data), 128'({5'd31, 5'd15, 5'd31, 5'd15, 8'b10110001}));
         end else begin
            if (t == 5)   check("m1_s0_c5_rd",   128'(w_rd_data), 128'({5'd5, 5'd5, 5'd5, 5'd5, 8'b11100100}));
            if (t == 18)  check("m1_s0_c5_wr",   128'(w_wr_data), 128'({5'd5, 5'd5, 5'd5, 5'd5, 8'b11100100}));
            if (t == 48)  check("m1_s1_c3_rd",   128'(w_rd_data), 128'({5'd3, 5'd2, 5'd1, 5'd0, 8'b00011011}));
            if (t == 61)  check("m1_s1_c3_wr",   128'(w_wr_data), 128'({5'd3, 5'd2, 5'd1, 5'd0, 8'b00011011}));
            if (t == 135) check("m1_tail_c0_rd", 128'(w_rd_data), 128'({5'd16, 5'd0, 5'd16, 5'd0, 8'b11100100}));
            if (t == 142) check("m1_tail_c0_wr", 128'(w_wr_data), 128'({5'd16, 5'd0, 5'd16, 5'd0, 8'b11100100}));
         end
         // A start request while busy must be ignored, even with the other mode.
         if (t == 100) begin
            bus.start = 1'b1;
            bus.mode  = ~m;
         end else begin
            bus.start = 1'b0;
            bus.mode  = m;
         end
         @(negedge clk);
      end
      check($sformatf("busy_cycles_m%0d", m), 128'(n_busy), 128'(total));
      check($sformatf("rd_cycles_m%0d", m),   128'(n_rd),   128'(exp_rw));
      check($sformatf("wr_cycles_m%0d", m),   128'(n_wr),   128'(exp_rw));
      check($sformatf("done_pulses_m%0d", m), 128'(n_done), 128'd1);
      check($sformatf("conflict_m%0d", m),    128'(bus.conflict_err), 128'd0);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", 128'(w_outs), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs", 128'(w_outs), 128'd0);

      run(1'b0, 273, 224, -1);
      run(1'b1, 174, 128, -1);
      run(1'b0, 273, 224, 50);
      run(1'b1, 174, 128, -1);
      run(1'b0, 273, 224, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ntt_stage_sched.md
# ntt_stage_sched

Parametrised stage scheduler for the 4-bank mixed-radix NTT datapath. Replaces the fixed-size fsm / address_generator / memory-map / shift_7 / shift_13 chain with one block. It sequences radix-2 or radix-4 stages for N = 2^LOG_N points and emits four conflict-free bank/row read addresses per cycle. It also emits the matching write-back addresses delayed by the butterfly latency of the current stage type, and stalls between stages until write-back completes.

## Interface
- LOG_N, default 7: log2 of transform size, 3..15; N/4 issue cycles per stage.
- BF_LAT, default 7: read-to-write latency of a radix-2 stage, ≥1.
- BF_LAT4, default 13: read-to-write latency of a radix-4 stage, ≥ BF_LAT.
- AW (derived, LOG_N-2): bank row width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin transform; sampled only in IDLE.
- mode  in  1  0 = all radix-2; 1 = radix-4, plus a radix-2 tail when LOG_N is odd.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse on return to IDLE.
- stage  out  4  current stage index, 0-based.
- r4  out  1  current stage is radix-4.
- cnt  out  AW  issue-cycle counter within the stage (twiddle generator input).
- rd_en  out  1  read addresses valid.
- rd_row  out  4*AW  lane m at [m*AW +: AW].
- rd_bank  out  8  lane m at [2m +: 2].
- wr_en, wr_row, wr_bank, wr_r4  out  1/4*AW/8/1  delayed copies of rd_en, rd_row, rd_bank, r4.
- conflict_err  out  1  sticky bank-conflict flag (see Configuration).

## Operation
- Stage list:
  - mode 0: LOG_N radix-2 stages, stride bit S = stage.
  - mode 1: floor(LOG_N/2) radix-4 stages on digit bits (2t, 2t+1) for t = stage; if LOG_N is odd, a final radix-2 stage with S = LOG_N-1.
- Partner bit Q for radix-2: Q = S^1 if S^1 < LOG_N, else bit 1 when S is even, bit 0 when S is odd.
- Positions: P0/P1 = 2t/2t+1 for radix-4; S/Q for radix-2.
- Index per issue cycle:
  - base a = cnt with zeros inserted at bits P0 and P1.
  - lane m index = a | m[0]<<P0 | m[1]<<P1.
  - radix-2 butterflies are lanes (0,1) and (2,3).
- Mapping:
  - bank = {XOR of odd-position bits, XOR of even-position bits}.
  - row = index[LOG_N-1:2].
  - The four lanes always land in distinct banks.
- FSM:
  - IDLE: start → ISSUE with stage=0, cnt=0.
  - ISSUE: rd_en=1 every cycle, cnt++. When cnt = N/4-1, go to DRAIN with dcnt = (r4 ? BF_LAT4 : BF_LAT).
  - DRAIN: rd_en=0, dcnt--. When dcnt reaches 1: if this is the last stage, go to IDLE and assert done; else stage++, cnt=0, go to ISSUE.
- start while busy: ignored.
- Write pipeline: a BF_LAT4-deep shift line carries rd_* fields and r4. The output tap is chosen per entry by its stored r4 flag, so a mixed-latency boundary never emits two writes in one cycle.
- Reset: every output and all state go to 0 (IDLE, pipeline valids cleared), including when reset arrives mid-transform.

## Timing
- start high at edge k → ISSUE at k+1; rd_en for cycles k+1..k+N/4.
- Each write appears exactly lat cycles after its read; the last write of a stage coincides with the final DRAIN cycle.
- The next stage's first read is the cycle after that, so the stage period is N/4 + lat.
- done rises the cycle after the final DRAIN cycle, with busy low.
- rd_* outputs are combinational from registered state.

## Configuration
- NTT_SCHED_CONFLICT_CHK_EN defined: a registered checker compares the four rd_bank lanes whenever rd_en is high. Any equal pair sets conflict_err, which only rst clears.
- Undefined: conflict_err is tied 0 and no checker logic is built.

## Test plan
- Defaults, mode 0, start pulse → busy for 7*(32+7) = 273 cycles, then a single-cycle done; 224 rd_en and 224 wr_en cycles.
- Mode 1 → 3*(32+13) + (32+7) = 174 busy cycles; r4 high for stages 0..2, low for stage 3.
- Mode 0, stage 2, cnt=1 → indices 1,5,9,13; rd_bank lanes 01,00,11,10; rd_row 0,1,2,3.
- Mode 1, final radix-2 stage, cnt=0 → indices 0,64,2,66; banks 00,01,10,11; rows 0,16,0,16.
- rst asserted mid-ISSUE of stage 1 → all outputs 0 immediately, and no wr_en after release; a new start runs the full schedule.
- With NTT_SCHED_CONFLICT_CHK_EN, a full run in both modes → conflict_err stays 0. Forcing two lanes equal → conflict_err sets and holds until rst.
